dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Arbitrates the dual-port data BRAM between three requesters:
  - the core memory stage (upper and lower lanes);
  - main-core external writes;
  - the single-word fetch/debug read path.
- Registers the BRAM port drive, generates the pipeline interlock, and sequences fetch reads through the BRAM read latency.
- Sits between the memory stage and the data RAM instance.

Parameters:
- ADDR_W, 17, word-address width; byte address driven as {(32-ADDR_W-2)'b0, addr, 2'b0}
- DATA_W, 32, data word width
- RD_LAT, 2, cycles from registered BRAM address to valid dout (min 1)
- STARVE_MAX, 8, cycles an external request may wait before it preempts the core

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- core_valid  in  1  core memory-stage request present
- core_u_addr / core_l_addr  in  ADDR_W  lane word addresses
- core_u_din / core_l_din  in  DATA_W  lane write data
- core_u_we / core_l_we  in  4  lane byte enables; 0 = read
- ext_valid  in  1  main-core write request
- ext_u_addr / ext_l_addr  in  ADDR_W  external word addresses
- ext_u_din / ext_l_din  in  DATA_W  external write data
- ext_u_we / ext_l_we  in  4  external byte enables
- ext_ready  out  1  one-cycle pulse: external request accepted
- fetch_req  in  1  fetch read request (level, held until fetch_valid)
- fetch_addr  in  ADDR_W  fetch word address
- fetch_valid  out  1  one-cycle pulse: fetch_data valid
- fetch_data  out  DATA_W  fetched word, held until next fetch completes
- stall  out  1  interlock to pipeline: core request not granted this cycle
- ram_addra / ram_addrb  out  32  BRAM byte addresses (registered)
- ram_dina / ram_dinb  out  DATA_W  BRAM write data (registered)
- ram_wea / ram_web  out  4  BRAM byte enables (registered)
- ram_douta  in  DATA_W  BRAM port-A read data

Behaviour:
Reset values:
- All ram_* outputs 0, ext_ready 0, fetch_valid 0, fetch_data 0, stall 0.
- FSM in IDLE; starvation counter 0.
- Reset mid-fetch aborts the fetch with no fetch_valid pulse; ram_we* are forced 0 immediately (async).

FSM states: IDLE, F_ISSUE, F_WAIT, F_DONE.

IDLE grant priority, evaluated each cycle:
1. ext, if ext_valid and starve == STARVE_MAX.
2. core, if core_valid.
3. ext, if ext_valid.
4. fetch, if fetch_req.

IDLE grant effects:
- Core or ext grant (cycle N): the granted lane u drives port A and lane l drives port B at N+1 (registered).
- Ext grant additionally: ext_ready = 1 in cycle N (combinational).
- Fetch grant: the FSM moves to F_ISSUE.
- No grant: ram_we* = 0 next cycle; addresses hold their previous values.

Fetch sequence:
- F_ISSUE:
  - port A: addr = fetch_addr, wea = 0;
  - port B: web = 0;
  - next state F_WAIT with counter = RD_LAT-1.
- F_WAIT: counts down. At 0, the cycle ram_douta is valid: fetch_data <= ram_douta, then F_DONE.
- F_DONE: fetch_valid = 1 for exactly one cycle, then IDLE.
- F_ISSUE, F_WAIT and F_DONE are non-preemptible; core and ext wait.
- Fetch latency: fetch_req sampled to fetch_valid = RD_LAT+2 cycles.
- fetch_req deasserted mid-sequence has no effect; the sequence completes.

Stall:
- stall = core_valid and (core not granted this cycle).
- Combinational, so the memory stage holds its request while stalled.

Starvation counter:
- Increments when ext_valid and ext is not granted; saturates at STARVE_MAX.
- Clears on ext grant or when ext_valid = 0.

Other rules:
- Simultaneous core + ext below the threshold: core wins, stall = 0, ext waits.
- Ext preemption (priority 1): stall = 1 for that one cycle.
- Same address on both ports in one grant: passed through unchanged; BRAM collision behaviour is the RAM's.
- Addresses are truncated to ADDR_W; no range check.

Decomposition:
- Shared package holds:
  - typedef dmem_req_t {addr[ADDR_W], din[DATA_W], we[4]};
  - enum dmem_arb_state_t {IDLE, F_ISSUE, F_WAIT, F_DONE};
  - constants DMEM_ADDR_W = 17 and DMEM_RD_LAT = 2.
- One sub-module, dmem_starve_cnt: the saturating starvation counter with inc/clr/at_max.
- Grant mux and FSM stay in the top module.

Test Plan:
1. Reset mid-fetch: rst asserted 1 cycle after fetch grant -> ram_we* = 0 immediately; no fetch_valid; FSM IDLE; fetch_data stays 0.
2. Core only: core_valid = 1, u_addr = 0x00010, u_we = 0xF, din = 0xDEADBEEF -> next cycle ram_addra = 0x00000040, ram_wea = 0xF, ram_dina = 0xDEADBEEF; stall = 0; ext_ready never pulses.
3. Core + ext contention: core_valid held high, ext_valid held high -> ext_ready = 0 for 8 cycles; 9th cycle ext_ready = 1 and stall = 1; port A shows ext_u_addr<<2 next cycle; counter back to 0.
4. Fetch latency: idle bus, fetch_req = 1, fetch_addr = 0x1FFFF, RAM returns 0x12345678 -> ram_addra = 0x0007FFFC with wea = 0; fetch_valid pulses exactly once, 4 cycles after the request is sampled; fetch_data = 0x12345678.
5. Fetch blocks core: core_valid rises in F_WAIT -> stall = 1 until the FSM returns to IDLE; core granted in the first IDLE cycle.
6. Byte write: core_l_we = 0x3, l_addr = 5 -> ram_web = 0x3, ram_addrb = 0x14; port A wea = 0 when core_u_we = 0.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Request bundle, arbiter FSM states and default widths.
package dmem_arbiter_pkg;

    localparam int DMEM_ADDR_W = 17;
    localparam int DMEM_RD_LAT = 2;

    typedef struct packed {
        logic [DMEM_ADDR_W-1:0] addr;
        logic [31:0]            din;
        logic [3:0]             we;
    } dmem_req_t;

    typedef enum logic [1:0] {
        IDLE,
        F_ISSUE,
        F_WAIT,
        F_DONE
    } dmem_arb_state_t;

endpackage

// File: rtl/dmem_starve_cnt.sv
// Saturating wait counter for the external write requester.
// at_max asserts once the requester has waited MAX cycles.
module dmem_starve_cnt #(
    parameter int MAX = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam int W = $clog2(MAX + 1);

    logic [W-1:0] cnt;

    assign at_max = (cnt == W'(MAX));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !at_max) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Dual-port data BRAM arbiter: core lanes, external writes, fetch reads.
// Registers the BRAM drive and produces the pipeline interlock.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = DMEM_ADDR_W,
    parameter int DATA_W     = 32,
    parameter int RD_LAT     = DMEM_RD_LAT,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_valid,
    input  logic [ADDR_W-1:0] core_u_addr,
    input  logic [ADDR_W-1:0] core_l_addr,
    input  logic [DATA_W-1:0] core_u_din,
    input  logic [DATA_W-1:0] core_l_din,
    input  logic [3:0]        core_u_we,
    input  logic [3:0]        core_l_we,
    input  logic              ext_valid,
    input  logic [ADDR_W-1:0] ext_u_addr,
    input  logic [ADDR_W-1:0] ext_l_addr,
    input  logic [DATA_W-1:0] ext_u_din,
    input  logic [DATA_W-1:0] ext_l_din,
    input  logic [3:0]        ext_u_we,
    input  logic [3:0]        ext_l_we,
    output logic              ext_ready,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_data,
    output logic              stall,
    output logic [31:0]       ram_addra,
    output logic [31:0]       ram_addrb,
    output logic [DATA_W-1:0] ram_dina,
    output logic [DATA_W-1:0] ram_dinb,
    output logic [3:0]        ram_wea,
    output logic [3:0]        ram_web,
    input  logic [DATA_W-1:0] ram_douta
);

    localparam int WW = $clog2(RD_LAT + 1);

    dmem_arb_state_t state, nstate;
    logic [WW-1:0]   wcnt;

    logic idle;
    logic at_max;
    logic ext_pre;
    logic grant_core;
    logic grant_ext;
    logic grant_fetch;

    dmem_req_t sel_u, sel_l;

    function automatic logic [31:0] byte_addr(input logic [ADDR_W-1:0] a);
        return {{(32-ADDR_W-2){1'b0}}, a, 2'b00};
    endfunction

    assign idle        = (state == IDLE);
    assign ext_pre     = idle && ext_valid && at_max;
    assign grant_core  = idle && core_valid && !ext_pre;
    assign grant_ext   = ext_pre || (idle && ext_valid && !core_valid);
    assign grant_fetch = idle && fetch_req && !core_valid && !ext_valid;

    assign ext_ready   = grant_ext;
    assign stall       = core_valid && !grant_core;
    assign fetch_valid = (state == F_DONE);

    always_comb begin
        sel_u = '0;
        sel_l = '0;
        if (grant_ext) begin
            sel_u = '{addr: ext_u_addr, din: ext_u_din, we: ext_u_we};
            sel_l = '{addr: ext_l_addr, din: ext_l_din, we: ext_l_we};
        end else begin
            sel_u = '{addr: core_u_addr, din: core_u_din, we: core_u_we};
            sel_l = '{addr: core_l_addr, din: core_l_din, we: core_l_we};
        end
    end

    dmem_starve_cnt #(
        .MAX (STARVE_MAX)
    ) u_starve (
        .clk    (clk),
        .rst    (rst),
        .inc    (ext_valid && !grant_ext),
        .clr    (!ext_valid || grant_ext),
        .at_max (at_max)
    );

    always_comb begin
        nstate = state;
        unique case (state)
            IDLE:    if (grant_fetch) nstate = F_ISSUE;
            F_ISSUE: nstate = F_WAIT;
            F_WAIT:  if (wcnt == '0) nstate = F_DONE;
            F_DONE:  nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nstate;
        end
    end

    // Read data is valid in the cycle the wait counter reaches zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt       <= '0;
            fetch_data <= '0;
        end else begin
            if (state == F_ISSUE) begin
                wcnt <= WW'(RD_LAT - 1);
            end else if (state == F_WAIT && wcnt != '0) begin
                wcnt <= wcnt - 1'b1;
            end
            if (state == F_WAIT && wcnt == '0) begin
                fetch_data <= ram_douta;
            end
        end
    end

    // The fetch address is loaded at grant so it is on port A during F_ISSUE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_addra <= '0;
            ram_addrb <= '0;
            ram_dina  <= '0;
            ram_dinb  <= '0;
            ram_wea   <= '0;
            ram_web   <= '0;
        end else if (grant_core || grant_ext) begin
            ram_addra <= byte_addr(sel_u.addr);
            ram_addrb <= byte_addr(sel_l.addr);
            ram_dina  <= sel_u.din;
            ram_dinb  <= sel_l.din;
            ram_wea   <= sel_u.we;
            ram_web   <= sel_l.we;
        end else begin
            ram_wea <= '0;
            ram_web <= '0;
            if (grant_fetch) begin
                ram_addra <= byte_addr(fetch_addr);
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a two-cycle BRAM read model.
// Writes and fetch results are queued at stimulus and popped by monitors.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    localparam int AW = 17;
    localparam int DW = 32;

    logic          clk = 0;
    logic          rst = 1;
    logic          core_valid = 0;
    logic [AW-1:0] core_u_addr = '0, core_l_addr = '0;
    logic [DW-1:0] core_u_din = '0, core_l_din = '0;
    logic [3:0]    core_u_we = '0, core_l_we = '0;
    logic          ext_valid = 0;
    logic [AW-1:0] ext_u_addr = '0, ext_l_addr = '0;
    logic [DW-1:0] ext_u_din = '0, ext_l_din = '0;
    logic [3:0]    ext_u_we = '0, ext_l_we = '0;
    logic          ext_ready;
    logic          fetch_req = 0;
    logic [AW-1:0] fetch_addr = '0;
    logic          fetch_valid;
    logic [DW-1:0] fetch_data;
    logic          stall;
    logic [31:0]   ram_addra, ram_addrb;
    logic [DW-1:0] ram_dina, ram_dinb;
    logic [3:0]    ram_wea, ram_web;
    logic [DW-1:0] ram_douta;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] aa, da, ab, db;
        logic [3:0]  wa, wb;
    } wr_t;

    typedef struct {
        logic [31:0] data;
        int          c;
    } fx_t;

    wr_t wq[$];
    fx_t fq[$];

    dmem_arbiter dut (
        .clk(clk), .rst(rst),
        .core_valid(core_valid),
        .core_u_addr(core_u_addr), .core_l_addr(core_l_addr),
        .core_u_din(core_u_din), .core_l_din(core_l_din),
        .core_u_we(core_u_we), .core_l_we(core_l_we),
        .ext_valid(ext_valid),
        .ext_u_addr(ext_u_addr), .ext_l_addr(ext_l_addr),
        .ext_u_din(ext_u_din), .ext_l_din(ext_l_din),
        .ext_u_we(ext_u_we), .ext_l_we(ext_l_we),
        .ext_ready(ext_ready),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_valid(fetch_valid), .fetch_data(fetch_data),
        .stall(stall),
        .ram_addra(ram_addra), .ram_addrb(ram_addrb),
        .ram_dina(ram_dina), .ram_dinb(ram_dinb),
        .ram_wea(ram_wea), .ram_web(ram_web),
        .ram_douta(ram_douta)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ram_word(input logic [31:0] a);
        if (a == 32'h0007_FFFC) return 32'h1234_5678;
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_A5A5;
    endfunction

    function automatic logic [31:0] ba(input logic [AW-1:0] a);
        return {13'b0, a, 2'b00};
    endfunction

    // BRAM model: dout reflects the address seen two cycles earlier.
    logic [31:0] a1 = '0, a2 = '0;
    always @(posedge clk) begin
        a1 <= ram_addra;
        a2 <= a1;
    end
    assign ram_douta = ram_word(a2);

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input logic [31:0] aa, input logic [3:0] wa,
                           input logic [31:0] da, input logic [31:0] ab,
                           input logic [3:0] wb, input logic [31:0] db);
        wr_t e;
        e.aa = aa; e.wa = wa; e.da = da;
        e.ab = ab; e.wb = wb; e.db = db;
        wq.push_back(e);
    endtask

    task automatic core_drive(input logic [AW-1:0] ua, input logic [3:0] uw,
                              input logic [31:0] ud, input logic [AW-1:0] la,
                              input logic [3:0] lw, input logic [31:0] ld);
        core_valid  = 1;
        core_u_addr = ua; core_u_we = uw; core_u_din = ud;
        core_l_addr = la; core_l_we = lw; core_l_din = ld;
    endtask

    always @(negedge clk) begin
        wr_t e;
        fx_t f;
        if (!rst) begin
            if (ram_wea != 0 || ram_web != 0) begin
                if (wq.size() == 0) begin
                    chk("wr_unexpected", {ram_wea, ram_web}, 0);
                end else begin
                    e = wq.pop_front();
                    chk("wr_addra", ram_addra, e.aa);
                    chk("wr_wea", ram_wea, e.wa);
                    chk("wr_dina", ram_dina, e.da);
                    chk("wr_addrb", ram_addrb, e.ab);
                    chk("wr_web", ram_web, e.wb);
                    chk("wr_dinb", ram_dinb, e.db);
                end
            end
            if (fetch_valid) begin
                if (fq.size() == 0) begin
                    chk("fetch_unexpected", 1, 0);
                end else begin
                    f = fq.pop_front();
                    chk("fetch_data", fetch_data, f.data);
                    chk("fetch_lat", cyc - f.c, 4);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        fx_t f;
        logic [AW-1:0] ra, rl;
        logic [3:0]    rw, rlw;
        logic [31:0]   rd, rld;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_addra", ram_addra, 0);
        chk("rst_addrb", ram_addrb, 0);
        chk("rst_dina", ram_dina, 0);
        chk("rst_dinb", ram_dinb, 0);
        chk("rst_we", {ram_wea, ram_web}, 0);
        chk("rst_ext_ready", ext_ready, 0);
        chk("rst_fetch_valid", fetch_valid, 0);
        chk("rst_fetch_data", fetch_data, 0);
        chk("rst_stall", stall, 0);
        rst = 0;
        tick();

        // Core only
        core_drive(17'h00010, 4'hF, 32'hDEAD_BEEF, 17'h00020, 4'h0, 32'h0);
        push_wr(32'h40, 4'hF, 32'hDEAD_BEEF, 32'h80, 4'h0, 32'h0);
        @(negedge clk);
        chk("core_stall", stall, 0);
        chk("core_no_ext_ready", ext_ready, 0);
        tick();
        core_valid = 0;
        @(negedge clk);
        chk("core_addra", ram_addra, 32'h0000_0040);
        chk("core_wea", ram_wea, 4'hF);

        // Byte write on lane l, lane u read
        tick();
        core_drive(17'h00033, 4'h0, 32'h1111, 17'h5, 4'h3, 32'hCAFE_F00D);
        push_wr(32'hCC, 4'h0, 32'h1111, 32'h14, 4'h3, 32'hCAFE_F00D);
        tick();
        core_valid = 0;
        @(negedge clk);
        chk("byte_web", ram_web, 4'h3);
        chk("byte_addrb", ram_addrb, 32'h14);
        chk("byte_wea", ram_wea, 4'h0);
        tick();
        @(negedge clk);
        chk("idle_we", {ram_wea, ram_web}, 0);
        chk("idle_addrb_hold", ram_addrb, 32'h14);

        // External only
        tick();
        ext_valid = 1;
        ext_u_addr = 17'h00100; ext_u_we = 4'hF; ext_u_din = 32'h0BAD_CAFE;
        ext_l_addr = 17'h00101; ext_l_we = 4'hC; ext_l_din = 32'h5555_AAAA;
        push_wr(ba(17'h100), 4'hF, 32'h0BAD_CAFE, ba(17'h101), 4'hC,
                32'h5555_AAAA);
        @(negedge clk);
        chk("ext_only_ready", ext_ready, 1);
        chk("ext_only_stall", stall, 0);
        tick();
        ext_valid = 0;

        // Contention: core reads starve the external writer
        tick();
        core_drive(17'h00200, 4'h0, 32'h0, 17'h00201, 4'h0, 32'h0);
        ext_valid = 1;
        ext_u_addr = 17'h1ABCD; ext_u_we = 4'hF; ext_u_din = 32'h7777_1234;
        ext_l_addr = 17'h00007; ext_l_we = 4'hF; ext_l_din = 32'h8888_4321;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("starve_ready_low", ext_ready, 0);
            chk("starve_stall_low", stall, 0);
            tick();
        end
        push_wr(32'h0006_AF34, 4'hF, 32'h7777_1234, ba(17'h7), 4'hF,
                32'h8888_4321);
        @(negedge clk);
        chk("preempt_ready", ext_ready, 1);
        chk("preempt_stall", stall, 1);
        tick();
        @(negedge clk);
        chk("preempt_addra", ram_addra, 32'h0006_AF34);
        chk("starve_cleared", ext_ready, 0);
        chk("post_preempt_stall", stall, 0);
        tick();
        core_valid = 0;
        ext_valid = 0;
        tick();

        // Fetch latency
        fetch_req = 1;
        fetch_addr = 17'h1FFFF;
        f.data = 32'h1234_5678; f.c = cyc;
        fq.push_back(f);
        tick();
        @(negedge clk);
        chk("fetch_issue_addra", ram_addra, 32'h0007_FFFC);
        chk("fetch_issue_wea", ram_wea, 0);
        chk("fetch_early_valid", fetch_valid, 0);
        tick();
        tick();
        tick();
        @(negedge clk);
        chk("fetch_pulse", fetch_valid, 1);
        tick();
        fetch_req = 0;
        @(negedge clk);
        chk("fetch_one_pulse", fetch_valid, 0);
        tick();
        tick();
        @(negedge clk);
        chk("fetch_data_hold", fetch_data, 32'h1234_5678);

        // Fetch blocks core; request dropped mid-sequence
        tick();
        fetch_req = 1;
        fetch_addr = 17'h00123;
        f.data = ram_word(32'h48C); f.c = cyc;
        fq.push_back(f);
        tick();
        fetch_req = 0;
        tick();
        core_drive(17'h00022, 4'hF, 32'hA0A0_0505, 17'h00023, 4'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("fetch_blocks_core", stall, 1);
            tick();
        end
        push_wr(ba(17'h22), 4'hF, 32'hA0A0_0505, ba(17'h23), 4'h0, 32'h0);
        @(negedge clk);
        chk("core_after_fetch", stall, 0);
        tick();
        core_valid = 0;

        // Random core writes
        for (int i = 0; i < 6; i++) begin
            ra = AW'($urandom); rl = AW'($urandom);
            rw = 4'($urandom_range(1, 15)); rlw = 4'($urandom);
            rd = $urandom; rld = $urandom;
            core_drive(ra, rw, rd, rl, rlw, rld);
            push_wr(ba(ra), rw, rd, ba(rl), rlw, rld);
            @(negedge clk);
            chk("rand_stall", stall, 0);
            tick();
        end
        core_valid = 0;
        tick();
        tick();

        // Async reset forces the write enables low immediately
        core_drive(17'h00044, 4'hF, 32'h1357_9BDF, 17'h00045, 4'hF, 32'h2);
        tick();
        core_valid = 0;
        chk("pre_rst_wea", ram_wea, 4'hF);
        rst = 1;
        #1;
        chk("rst_async_wea", ram_wea, 0);
        chk("rst_async_web", ram_web, 0);
        @(negedge clk);
        rst = 0;
        tick();

        // Reset mid-fetch
        fetch_req = 1;
        fetch_addr = 17'h00055;
        tick();
        rst = 1;
        fetch_req = 0;
        #1;
        chk("rst_fetch_we", {ram_wea, ram_web}, 0);
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            @(negedge clk);
            chk("rst_fetch_no_valid", fetch_valid, 0);
        end
        chk("rst_fetch_data", fetch_data, 0);
        tick();
        core_drive(17'h00066, 4'h5, 32'h2468_ACE0, 17'h00067, 4'h0, 32'h0);
        push_wr(ba(17'h66), 4'h5, 32'h2468_ACE0, ba(17'h67), 4'h0, 32'h0);
        @(negedge clk);
        chk("rst_fsm_idle", stall, 0);
        tick();
        core_valid = 0;

        repeat (3) tick();
        chk("wq_empty", wq.size(), 0);
        chk("fq_empty", fq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
